sad_accum_min: RTL and testbench
================================

SAD_ACCUM_MIN -- requirements
Module: sad_accum_min

Interface
REQ-001 Parameter PIXEL, default 8, pixel and abs-difference width in bits.
REQ-002 Parameter NUM_PE, default 8, number of PE abs_out values consumed per beat (one block row).
REQ-003 Parameter ROWS, default 8, beats per candidate block (block height).
REQ-004 Parameter MV_W, default 6, signed motion-vector component width.
REQ-005 Derived localparam SAD_W = PIXEL + clog2(NUM_PE*ROWS), i.e. 14 at defaults; no overflow is possible at this width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 abs_in  input  NUM_PE*PIXEL  PE abs_out values, unsigned; PE k occupies bits [k*PIXEL +: PIXEL].
REQ-009 abs_valid  input  1  abs_in holds one valid row this cycle.
REQ-010 search_start  input  1  qualified by abs_valid; this beat is row 0 of the first candidate of a new search.
REQ-011 search_last  input  1  qualified by abs_valid; this beat belongs to the last candidate of the search.
REQ-012 cand_mv_x, cand_mv_y  input  MV_W each  signed candidate MV, sampled on row 0 of each candidate.
REQ-013 sad_out  output  SAD_W  SAD of the most recently completed candidate.
REQ-014 sad_valid  output  1  one-cycle pulse; sad_out is new this cycle.
REQ-015 min_sad  output  SAD_W  smallest SAD so far in the current search.
REQ-016 best_mv_x, best_mv_y  output  MV_W each  MV of the candidate holding min_sad.
REQ-017 done  output  1  one-cycle pulse; the search is complete and min_sad/best_mv are final.

Function
REQ-018 Stage 1: on an abs_valid beat, the block SHALL register the unsigned sum of the NUM_PE abs values, plus a valid flag, 1 cycle after the beat.
REQ-019 Stage 2: a row counter 0..ROWS-1 SHALL advance on each stage-1-valid cycle, clear the accumulator on row 0, add on rows 1..ROWS-1, and wrap to 0 after row ROWS-1.
REQ-020 Gaps SHALL be allowed: cycles with abs_valid low hold all counters and the accumulator unchanged.
REQ-021 cand_mv_x/y and the search_last flag SHALL travel with the pipeline; the MV is captured on row 0, and search_last is OR-latched across the candidate's beats.
REQ-022 After the ROWS-th beat at cycle t, sad_out SHALL hold the full SAD and sad_valid SHALL pulse at t+2.
REQ-023 Stage 3, at t+3: when the candidate is the first of a search, or sad_out < min_sad (strict), min_sad and best_mv SHALL take the candidate's values; otherwise they hold.
REQ-024 On a tie, the earlier candidate SHALL be kept.
REQ-025 done SHALL pulse at t+3 for the candidate carrying search_last, together with the final min_sad/best_mv update.
REQ-026 search_start on a beat while the row counter is not 0 SHALL discard the partial candidate and restart at row 0 with that beat.
REQ-027 search_start with abs_valid low SHALL be ignored.
REQ-028 After done, min_sad and best_mv SHALL hold until the first candidate of the next search completes stage 3.
REQ-029 Back-to-back candidates with no idle cycles SHALL be sustained at one row per cycle with no lost beats.
REQ-030 sad_valid and done SHALL never be asserted for more than one consecutive cycle per candidate.

Reset
REQ-031 While rst_n is low, the row counter, all pipeline valids and flags, and sad_out SHALL be 0; min_sad SHALL be all-ones; best_mv_x/y SHALL be 0; sad_valid and done SHALL be 0.
REQ-032 Reset asserted mid-candidate or mid-search SHALL abandon all partial work; the first valid beat after release is treated as row 0.

Verification
REQ-033 One candidate, all abs=1, search_start and search_last set, MV=(3,-2), 8 consecutive beats -> sad_valid and done pulse 2 and 3 cycles after the last beat, with sad_out=64, min_sad=64, best_mv=(3,-2).
REQ-034 Three candidates with SADs 500, 300, 300 at MVs (0,0), (1,0), (2,0) -> done after the third, with min_sad=300, best_mv=(1,0) (tie kept).
REQ-035 All abs=255 for one candidate -> sad_out=16320, no wrap.
REQ-036 Candidate delivered with random abs_valid gaps -> same SAD as the gap-free delivery; exactly one sad_valid.
REQ-037 search_start reasserted on row 4 of a candidate -> the partial SAD is discarded; the next SAD covers 8 beats starting at the restart beat.
REQ-038 rst_n pulsed low during row 5 -> outputs at reset values; the next 8 beats form a fresh candidate with the correct SAD.

Source files
------------

// File: rtl/sad_accum_min.sv
// Sum-of-absolute-differences accumulator for block motion search: adds one PE row
// per beat, emits the SAD for each candidate and tracks the smallest SAD and its MV.
module sad_accum_min #(
    parameter int PIXEL  = 8,
    parameter int NUM_PE = 8,
    parameter int ROWS   = 8,
    parameter int MV_W   = 6,
    localparam int SAD_W = PIXEL + $clog2(NUM_PE * ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PE*PIXEL-1:0] abs_in,
    input  logic                    abs_valid,
    input  logic                    search_start,
    input  logic                    search_last,
    input  logic [MV_W-1:0]         cand_mv_x,
    input  logic [MV_W-1:0]         cand_mv_y,
    output logic [SAD_W-1:0]        sad_out,
    output logic                    sad_valid,
    output logic [SAD_W-1:0]        min_sad,
    output logic [MV_W-1:0]         best_mv_x,
    output logic [MV_W-1:0]         best_mv_y,
    output logic                    done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [SAD_W-1:0] w_row_sum;
    logic [SAD_W-1:0] r_s1_sum;
    logic             r_s1_valid, r_s1_start, r_s1_last;
    logic [MV_W-1:0]  r_s1_mvx, r_s1_mvy;

    logic [RW-1:0]    r_row;
    logic [SAD_W-1:0] r_acc;
    logic             r_cand_last, r_cand_first;
    logic [MV_W-1:0]  r_cand_mvx, r_cand_mvy;

    logic [SAD_W-1:0] r_sad_out;
    logic             r_sad_valid, r_out_last, r_out_first;
    logic [MV_W-1:0]  r_out_mvx, r_out_mvy;

    logic [SAD_W-1:0] r_min_sad;
    logic [MV_W-1:0]  r_best_mvx, r_best_mvy;
    logic             r_done;

    logic [RW-1:0]    w_row_eff;
    logic             w_row0, w_row_end;
    logic [SAD_W-1:0] w_acc_next;
    logic             w_last_next, w_first_next;
    logic [MV_W-1:0]  w_mvx_next, w_mvy_next;

    always_comb begin
        w_row_sum = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            w_row_sum = w_row_sum + SAD_W'(abs_in[k*PIXEL +: PIXEL]);
        end
    end

    // A start beat always opens a fresh candidate, discarding any partial rows.
    always_comb begin
        w_row_eff    = r_s1_start ? '0 : r_row;
        w_row0       = (w_row_eff == '0);
        w_row_end    = (w_row_eff == RW'(ROWS - 1));
        w_acc_next   = w_row0 ? r_s1_sum : r_acc + r_s1_sum;
        w_last_next  = w_row0 ? r_s1_last : (r_cand_last | r_s1_last);
        w_first_next = w_row0 ? r_s1_start : r_cand_first;
        w_mvx_next   = w_row0 ? r_s1_mvx : r_cand_mvx;
        w_mvy_next   = w_row0 ? r_s1_mvy : r_cand_mvy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_start <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mvx   <= '0;
            r_s1_mvy   <= '0;
        end else begin
            r_s1_valid <= abs_valid;
            if (abs_valid) begin
                r_s1_sum   <= w_row_sum;
                r_s1_start <= search_start;
                r_s1_last  <= search_last;
                r_s1_mvx   <= cand_mv_x;
                r_s1_mvy   <= cand_mv_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_acc        <= '0;
            r_cand_last  <= 1'b0;
            r_cand_first <= 1'b0;
            r_cand_mvx   <= '0;
            r_cand_mvy   <= '0;
            r_sad_valid  <= 1'b0;
            r_sad_out    <= '0;
            r_out_last   <= 1'b0;
            r_out_first  <= 1'b0;
            r_out_mvx    <= '0;
            r_out_mvy    <= '0;
        end else begin
            r_sad_valid <= r_s1_valid & w_row_end;
            if (r_s1_valid) begin
                r_row        <= w_row_end ? '0 : w_row_eff + RW'(1);
                r_acc        <= w_acc_next;
                r_cand_last  <= w_last_next;
                r_cand_first <= w_first_next;
                r_cand_mvx   <= w_mvx_next;
                r_cand_mvy   <= w_mvy_next;
                if (w_row_end) begin
                    r_sad_out   <= w_acc_next;
                    r_out_last  <= w_last_next;
                    r_out_first <= w_first_next;
                    r_out_mvx   <= w_mvx_next;
                    r_out_mvy   <= w_mvy_next;
                end
            end
        end
    end

    // Strict less-than keeps the earlier candidate on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_sad  <= '1;
            r_best_mvx <= '0;
            r_best_mvy <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= r_sad_valid & r_out_last;
            if (r_sad_valid && (r_out_first || (r_sad_out < r_min_sad))) begin
                r_min_sad  <= r_sad_out;
                r_best_mvx <= r_out_mvx;
                r_best_mvy <= r_out_mvy;
            end
        end
    end

    assign sad_out   = r_sad_out;
    assign sad_valid = r_sad_valid;
    assign min_sad   = r_min_sad;
    assign best_mv_x = r_best_mvx;
    assign best_mv_y = r_best_mvy;
    assign done      = r_done;
endmodule

// File: tb/tb_sad_accum_min.sv
// Directed bench for sad_accum_min at default parameters: hand-computed SADs,
// pulse timing, tie handling, gaps, mid-candidate restart and reset.
module tb_sad_accum_min;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] abs_in;
    logic        abs_valid, search_start, search_last;
    logic [5:0]  cand_mv_x, cand_mv_y;
    logic [13:0] sad_out, min_sad;
    logic        sad_valid, done;
    logic [5:0]  best_mv_x, best_mv_y;

    int vecs = 0;
    int errs = 0;
    int sv_cnt = 0;
    int dn_cnt = 0;
    logic [13:0] obs_q[$];
    logic [13:0] exp_q[$];

    sad_accum_min dut (
        .clk(clk), .rst_n(rst_n), .abs_in(abs_in), .abs_valid(abs_valid),
        .search_start(search_start), .search_last(search_last),
        .cand_mv_x(cand_mv_x), .cand_mv_y(cand_mv_y),
        .sad_out(sad_out), .sad_valid(sad_valid), .min_sad(min_sad),
        .best_mv_x(best_mv_x), .best_mv_y(best_mv_y), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sad_valid) begin
            sv_cnt++;
            obs_q.push_back(sad_out);
        end
        if (done) dn_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vecs++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One beat: PE0 carries a, PEs 1..7 carry b, so the row sum is a + 7*b.
    task automatic send_row(input logic [7:0] a, input logic [7:0] b, input logic st,
                            input logic ls, input logic [5:0] mx, input logic [5:0] my);
        for (int k = 0; k < 8; k++) abs_in[k*8 +: 8] = (k == 0) ? a : b;
        abs_valid = 1'b1; search_start = st; search_last = ls;
        cand_mv_x = mx; cand_mv_y = my;
        @(posedge clk); #1;
        abs_valid = 1'b0; search_start = 1'b0; search_last = 1'b0;
    endtask

    task automatic send_cand(input logic [7:0] v, input logic st, input logic ls,
                             input logic [5:0] mx, input logic [5:0] my);
        for (int r = 0; r < 8; r++) send_row(v, v, st && r == 0, ls, mx, my);
    endtask

    // Called one cycle after the last beat; walks the t+1..t+4 window.
    task automatic check_cand(input string tag, input logic [13:0] exp_sad, input logic exp_done,
                              input logic [13:0] prev_min, input logic [13:0] exp_min,
                              input logic [5:0] exp_mx, input logic [5:0] exp_my);
        chk({tag, "_sv_early"}, sad_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_sv"}, sad_valid, 1);
        chk({tag, "_sad"}, sad_out, exp_sad);
        chk({tag, "_min_hold"}, min_sad, prev_min);
        chk({tag, "_done_early"}, done, 0);
        @(posedge clk); #1;
        chk({tag, "_sv_off"}, sad_valid, 0);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_min"}, min_sad, exp_min);
        chk({tag, "_mvx"}, best_mv_x, exp_mx);
        chk({tag, "_mvy"}, best_mv_y, exp_my);
        @(posedge clk); #1;
        chk({tag, "_done_off"}, done, 0);
    endtask

    initial begin
        int sv0, dn0, idx0;
        rst_n = 1'b0; abs_in = '0; abs_valid = 1'b0; search_start = 1'b0;
        search_last = 1'b0; cand_mv_x = '0; cand_mv_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sad", sad_out, 0);
        chk("rst_sv", sad_valid, 0);
        chk("rst_min", min_sad, 14'h3fff);
        chk("rst_mvx", best_mv_x, 0);
        chk("rst_mvy", best_mv_y, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single candidate, abs=1 everywhere, MV (3,-2)
        send_cand(8'd1, 1'b1, 1'b1, 6'd3, 6'h3e);
        check_cand("one", 14'd64, 1'b1, 14'h3fff, 14'd64, 6'd3, 6'h3e);

        // SADs 500, 300, 300: row sums 7*64 + 52 and 7*40 + 20
        for (int r = 0; r < 7; r++) send_row(8'd8, 8'd8, r == 0, 1'b0, 6'd0, 6'd0);
        send_row(8'd3, 8'd7, 1'b0, 1'b0, 6'd0, 6'd0);
        check_cand("c500", 14'd500, 1'b0, 14'd64, 14'd500, 6'd0, 6'd0);
        for (int r = 0; r < 7; r++) send_row(8'd5, 8'd5, 1'b0, 1'b0, 6'd1, 6'd0);
        send_row(8'd6, 8'd2, 1'b0, 1'b0, 6'd1, 6'd0);
        check_cand("c300a", 14'd300, 1'b0, 14'd500, 14'd300, 6'd1, 6'd0);
        for (int r = 0; r < 7; r++) send_row(8'd5, 8'd5, 1'b0, 1'b1, 6'd2, 6'd0);
        send_row(8'd6, 8'd2, 1'b0, 1'b1, 6'd2, 6'd0);
        check_cand("c300tie", 14'd300, 1'b1, 14'd300, 14'd300, 6'd1, 6'd0);

        // maximum magnitude
        send_cand(8'd255, 1'b1, 1'b1, 6'd5, 6'd4);
        check_cand("max", 14'd16320, 1'b1, 14'd300, 14'd16320, 6'd5, 6'd4);

        // random gaps between beats
        sv0 = sv_cnt; dn0 = dn_cnt;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_row(8'd3, 8'd3, r == 0, 1'b1, 6'h3f, 6'd1);
        end
        check_cand("gap", 14'd192, 1'b1, 14'd16320, 14'd192, 6'h3f, 6'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("gap_sv_count", sv_cnt - sv0, 1);
        chk("gap_done_count", dn_cnt - dn0, 1);

        // restart on row 4: 8 rows of 16 from the restart beat
        for (int r = 0; r < 4; r++) send_row(8'd10, 8'd10, r == 0, 1'b0, 6'd9, 6'd9);
        for (int r = 0; r < 8; r++) send_row(8'd2, 8'd2, r == 0, 1'b1, 6'd7, 6'h3d);
        check_cand("restart", 14'd128, 1'b1, 14'd192, 14'd128, 6'd7, 6'h3d);

        // reset during row 5
        for (int r = 0; r < 5; r++) send_row(8'd9, 8'd9, r == 0, 1'b0, 6'd2, 6'd2);
        for (int k = 0; k < 8; k++) abs_in[k*8 +: 8] = 8'd9;
        abs_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        abs_valid = 1'b0;
        chk("mrst_sad", sad_out, 0);
        chk("mrst_min", min_sad, 14'h3fff);
        chk("mrst_mvx", best_mv_x, 0);
        chk("mrst_sv", sad_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_cand(8'd4, 1'b0, 1'b1, 6'h3d, 6'd7);
        check_cand("postrst", 14'd256, 1'b1, 14'h3fff, 14'd256, 6'h3d, 6'd7);

        // back-to-back candidates without idle cycles
        sv0 = sv_cnt; dn0 = dn_cnt; idx0 = obs_q.size();
        exp_q.push_back(14'd384);
        exp_q.push_back(14'd128);
        send_cand(8'd6, 1'b1, 1'b0, 6'd4, 6'd4);
        send_cand(8'd2, 1'b0, 1'b1, 6'h3f, 6'd5);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_sv_count", sv_cnt - sv0, 2);
        chk("b2b_done_count", dn_cnt - dn0, 1);
        for (int i = 0; i < 2; i++) begin
            if (obs_q.size() > idx0 + i) chk("b2b_sad", obs_q[idx0 + i], exp_q.pop_front());
        end
        chk("b2b_min", min_sad, 14'd128);
        chk("b2b_mvx", best_mv_x, 6'h3f);
        chk("b2b_mvy", best_mv_y, 6'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
